// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-request record that reg_file and
// the writeback arbiter exchange.
package rf_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;
    localparam int PPP_W  = 3;

    localparam logic [PPP_W-1:0] PPP_FULL = 3'b000;

    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_STARVE_MAX = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PPP_W-1:0]  ppp;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: ALU and load producers plus the scoreboard query on the driving
// side, and the reg_file write port on the arbiter side.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              alu_vld;
    logic [ADDR_W-1:0] alu_addr;
    logic [PPP_W-1:0]  alu_ppp;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;

    logic              ld_vld;
    logic              ld_rdy;
    logic [ADDR_W-1:0] ld_addr;
    logic [PPP_W-1:0]  ld_ppp;
    logic [DATA_W-1:0] ld_data;

    logic              wr_en;
    logic [PPP_W-1:0]  ppp;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    logic [ADDR_W-1:0] chk_addr;
    logic              chk_hit;
    logic [CNT_W-1:0]  fifo_cnt;

    modport master (
        output alu_vld, alu_addr, alu_ppp, alu_data,
        output ld_vld, ld_addr, ld_ppp, ld_data, chk_addr,
        input  alu_stall, ld_rdy, wr_en, ppp, in_addr, in_data, chk_hit, fifo_cnt
    );

    modport slave (
        input  alu_vld, alu_addr, alu_ppp, alu_data,
        input  ld_vld, ld_addr, ld_ppp, ld_data, chk_addr,
        output alu_stall, ld_rdy, wr_en, ppp, in_addr, in_data, chk_hit, fifo_cnt
    );
endinterface

// File: rtl/wb_fifo.sv
// Load-result buffer: power-of-two ring FIFO that also exposes every entry's
// address and validity so the scoreboard compare can see buffered writes.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wr_req_t                          push_req,
    input  logic                             pop,
    output wr_req_t                          head,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0]                 ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]     ent_addr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_req_t          mem_q [DEPTH];
    wr_req_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    logic [PTR_W-1:0] off;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off         = PTR_W'(i) - rd_ptr_q;
            ent_vld[i]  = ({1'b0, off} < count_q);
            ent_addr[i] = mem_q[i].addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges ALU results (priority) and buffered load results onto the single
// reg_file write port, forcing a load through after STARVE_MAX ALU wins.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic             stall_q, stall_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             wr_en_q, wr_en_d;
    wr_req_t          req_q, req_d;

    logic             alu_win, fifo_win;
    logic             fifo_full, fifo_empty;
    wr_req_t          fifo_head, ld_req, alu_req;
    logic [CNT_W-1:0] fifo_count;
    logic [FIFO_DEPTH-1:0]             ent_vld;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic             ld_push, hit;

    assign alu_req = '{addr: bus.alu_addr, ppp: bus.alu_ppp, data: bus.alu_data};
    assign ld_req  = '{addr: bus.ld_addr,  ppp: bus.ld_ppp,  data: bus.ld_data};
    assign ld_push = bus.ld_vld && bus.ld_rdy;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ld_push),
        .push_req (ld_req),
        .pop      (fifo_win),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ent_vld  (ent_vld),
        .ent_addr (ent_addr)
    );

    always_comb begin
        alu_win  = bus.alu_vld && !stall_q;
        fifo_win = !fifo_empty && (!bus.alu_vld || stall_q);
        wr_en_d  = alu_win || fifo_win;
        req_d    = req_q;
        if (alu_win) begin
            req_d = alu_req;
        end else if (fifo_win) begin
            req_d = fifo_head;
        end

        // Only ALU wins over a waiting load count; the last tolerated one arms a one-cycle stall.
        stall_d  = 1'b0;
        starve_d = '0;
        if (alu_win && !fifo_empty) begin
            if (starve_q == STV_W'(STARVE_MAX - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + STV_W'(1);
            end
        end
    end

    always_comb begin
        hit = wr_en_q && (req_q.addr == bus.chk_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == bus.chk_addr)) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= 1'b0;
            starve_q <= '0;
            wr_en_q  <= 1'b0;
            req_q    <= '{addr: '0, ppp: PPP_FULL, data: '0};
        end else begin
            stall_q  <= stall_d;
            starve_q <= starve_d;
            wr_en_q  <= wr_en_d;
            req_q    <= req_d;
        end
    end

    assign bus.alu_stall = stall_q;
    assign bus.ld_rdy    = !fifo_full && !rst;
    assign bus.wr_en     = wr_en_q;
    assign bus.ppp       = req_q.ppp;
    assign bus.in_addr   = req_q.addr;
    assign bus.in_data   = req_q.data;
    assign bus.chk_hit   = hit;
    assign bus.fifo_cnt  = fifo_count;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference of the arbitration rules.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: loads queue in arrival order, ALU wins unless the arbiter is stalling,
    // and a stall follows SMAX consecutive ALU wins over a waiting load.
    wr_req_t mq[$];
    wr_req_t m_req = '0;
    bit      m_wr, m_stall, m_alu_taken, m_ld_taken;
    int      m_starve;

    always @(posedge clk or posedge rst) begin : model
        int      n;
        bit      aw, fw;
        wr_req_t nr;
        if (rst) begin
            mq.delete();
            m_wr = 0; m_stall = 0; m_starve = 0; m_req = '0;
            m_alu_taken = 0; m_ld_taken = 0;
        end else begin
            n  = mq.size();
            aw = bus.alu_vld && !m_stall;
            fw = (n > 0) && !aw;
            m_alu_taken = aw;
            m_ld_taken  = bus.ld_vld && (n < DEPTH);
            if (aw) begin
                m_wr = 1;
                m_req.addr = bus.alu_addr; m_req.ppp = bus.alu_ppp; m_req.data = bus.alu_data;
            end else if (fw) begin
                m_wr = 1;
                m_req = mq.pop_front();
            end else begin
                m_wr = 0;
            end
            if (aw && n > 0) m_starve++;
            else m_starve = 0;
            m_stall = (m_starve == SMAX);
            if (m_stall) m_starve = 0;
            if (m_ld_taken) begin
                nr.addr = bus.ld_addr; nr.ppp = bus.ld_ppp; nr.data = bus.ld_data;
                mq.push_back(nr);
            end
        end
    end

    logic [ADDR_W-1:0] wlog_a[$];
    logic [DATA_W-1:0] wlog_d[$];
    int alu_seq = 0;

    task automatic compare_all();
        bit hit;
        hit = m_wr && (m_req.addr == bus.chk_addr);
        foreach (mq[i]) if (mq[i].addr == bus.chk_addr) hit = 1;
        check_val("wr_en",     64'(bus.wr_en),     64'(m_wr));
        check_val("in_addr",   64'(bus.in_addr),   64'(m_req.addr));
        check_val("ppp",       64'(bus.ppp),       64'(m_req.ppp));
        check_val("in_data",   bus.in_data,        m_req.data);
        check_val("alu_stall", 64'(bus.alu_stall), 64'(m_stall));
        check_val("fifo_cnt",  64'(bus.fifo_cnt),  64'(mq.size()));
        check_val("ld_rdy",    64'(bus.ld_rdy),    64'(!rst && mq.size() < DEPTH));
        check_val("chk_hit",   64'(bus.chk_hit),   64'(hit));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (bus.wr_en) begin
            wlog_a.push_back(bus.in_addr);
            wlog_d.push_back(bus.in_data);
        end
    endtask

    task automatic alu_present();
        bus.alu_vld  = 1'b1;
        bus.alu_addr = 6'(32 + alu_seq % 32);
        bus.alu_ppp  = 3'(alu_seq);
        bus.alu_data = 64'(alu_seq);
    endtask

    task automatic busy_tick();
        tick();
        if (m_alu_taken) begin
            alu_seq++;
            alu_present();
        end
    endtask

    task automatic alu_release();
        for (int i = 0; i < 4 && m_stall; i++) busy_tick();
        bus.alu_vld = 1'b0;
    endtask

    task automatic seq_check(input int s0);
        int exp = s0;
        foreach (wlog_a[i]) begin
            if (wlog_a[i] >= 32) begin
                check_val("alu_seq", wlog_d[i], 64'(exp));
                exp++;
            end
        end
    endtask

    task automatic set_ld(input bit v, input logic [ADDR_W-1:0] a, input logic [PPP_W-1:0] p,
                          input logic [DATA_W-1:0] d);
        bus.ld_vld = v; bus.ld_addr = a; bus.ld_ppp = p; bus.ld_data = d;
    endtask

    logic [ADDR_W-1:0] lds [5] = '{6'd12, 6'd13, 6'd14, 6'd15, 6'd9};

    initial begin
        int s0, li, nload, cyc, pos, k;
        bit seen_full, drained;
        bus.alu_vld = 0; bus.alu_addr = 0; bus.alu_ppp = 0; bus.alu_data = 0;
        set_ld(0, 0, 0, 0);
        bus.chk_addr = 6'd63;
        #1 rst = 1'b1;
        @(negedge clk);
        compare_all();
        check_val("rst_wr_en", 64'(bus.wr_en), 64'(0));
        check_val("rst_rdy", 64'(bus.ld_rdy), 64'(0));
        rst = 1'b0;
        #1 check_val("rel_rdy", 64'(bus.ld_rdy), 64'(1));

        // ALU only, single then back-to-back
        bus.alu_vld = 1; bus.alu_addr = 17; bus.alu_ppp = 0; bus.alu_data = 64'hDEAD_BEEF_0123_4567;
        tick();
        check_val("alu17_wr", 64'(bus.wr_en), 64'(1));
        check_val("alu17_addr", 64'(bus.in_addr), 64'(17));
        check_val("alu17_data", bus.in_data, 64'hDEAD_BEEF_0123_4567);
        bus.alu_addr = 22; bus.alu_ppp = 3'b010; bus.alu_data = 64'h22;
        tick();
        check_val("alu22_addr", 64'(bus.in_addr), 64'(22));
        check_val("alu22_ppp", 64'(bus.ppp), 64'(2));
        bus.alu_addr = 13; bus.alu_data = 64'h13;
        tick();
        check_val("alu13_addr", 64'(bus.in_addr), 64'(13));
        check_val("alu13_wr", 64'(bus.wr_en), 64'(1));
        bus.alu_vld = 0;
        tick();
        check_val("alu_idle_wr", 64'(bus.wr_en), 64'(0));

        // Load only
        set_ld(1, 12, 3'b100, 64'hABCD);
        tick();
        bus.ld_vld = 0;
        check_val("ld_cnt1", 64'(bus.fifo_cnt), 64'(1));
        check_val("ld_nowr", 64'(bus.wr_en), 64'(0));
        tick();
        check_val("ld_wr", 64'(bus.wr_en), 64'(1));
        check_val("ld_addr", 64'(bus.in_addr), 64'(12));
        check_val("ld_ppp", 64'(bus.ppp), 64'(4));
        tick();

        // Reset mid-stream with three loads buffered
        alu_present();
        for (int i = 0; i < 3; i++) begin
            set_ld(1, 6'(20 + i), 3'(i), 64'(200 + i));
            busy_tick();
        end
        bus.ld_vld = 0;
        check_val("pre_rst_cnt", 64'(bus.fifo_cnt), 64'(3));
        rst = 1'b1;
        bus.alu_vld = 0;
        #1;
        compare_all();
        check_val("mid_rst_cnt", 64'(bus.fifo_cnt), 64'(0));
        check_val("mid_rst_rdy", 64'(bus.ld_rdy), 64'(0));
        check_val("mid_rst_data", bus.in_data, 64'(0));
        tick();
        rst = 1'b0;
        #1 check_val("mid_rel_rdy", 64'(bus.ld_rdy), 64'(1));
        tick();

        // Full FIFO under continuous ALU traffic
        wlog_a.delete(); wlog_d.delete();
        s0 = alu_seq; alu_present();
        li = 0; nload = 0; cyc = 0; seen_full = 0;
        while (nload < 5 && cyc < 300) begin
            if (li < 5) set_ld(1, lds[li], 3'(li), 64'(100 + li));
            else bus.ld_vld = 0;
            busy_tick();
            cyc++;
            if (m_ld_taken) li++;
            if (li == 4 && !seen_full) begin
                seen_full = 1;
                check_val("full_rdy", 64'(bus.ld_rdy), 64'(0));
            end
            if (bus.wr_en && bus.in_addr < 32) nload++;
        end
        bus.ld_vld = 0;
        check_val("full_done", 64'(nload), 64'(5));
        k = 0;
        foreach (wlog_a[i]) begin
            if (wlog_a[i] < 32 && k < 5) begin
                check_val("ld_order", 64'(wlog_a[i]), 64'(lds[k]));
                k++;
            end
        end
        seq_check(s0);
        alu_release();
        tick();

        // Starvation: one load waits behind a continuous ALU stream
        wlog_a.delete(); wlog_d.delete();
        s0 = alu_seq; alu_present();
        set_ld(1, 5, 3'b011, 64'h5555);
        busy_tick();
        bus.ld_vld = 0;
        pos = -1; cyc = 0;
        while (pos < 0 && cyc < 40) begin
            foreach (wlog_a[i]) if (wlog_a[i] == 5 && pos < 0) pos = i;
            if (pos < 0) begin
                busy_tick();
                cyc++;
            end
        end
        busy_tick();
        check_val("starve_pos", 64'(pos), 64'(SMAX + 1));
        check_val("starve_after", 64'(wlog_a.size()), 64'(SMAX + 3));
        seq_check(s0);
        alu_release();
        tick();

        // chk_hit against buffered loads, then after drain
        alu_present();
        set_ld(1, 9, 0, 64'h9);
        busy_tick();
        set_ld(1, 15, 0, 64'hF);
        busy_tick();
        bus.ld_vld = 0;
        bus.chk_addr = 15;
        #1 check_val("chk15", 64'(bus.chk_hit), 64'(1));
        bus.chk_addr = 16;
        #1 check_val("chk16", 64'(bus.chk_hit), 64'(0));
        bus.chk_addr = 9;
        #1 check_val("chk9", 64'(bus.chk_hit), 64'(1));
        alu_release();
        drained = 0; cyc = 0;
        while (!drained && cyc < 30) begin
            tick();
            cyc++;
            drained = (bus.fifo_cnt == 0) && !bus.wr_en;
        end
        check_val("chk_drained", 64'(drained), 64'(1));
        bus.chk_addr = 15;
        #1 check_val("chk15_gone", 64'(bus.chk_hit), 64'(0));

        // Random traffic; producers hold a result until it is taken
        for (int c = 0; c < 2000; c++) begin
            if (!(bus.alu_vld && !m_alu_taken)) begin
                bus.alu_vld  = ($urandom_range(0, 9) < 6);
                bus.alu_addr = 6'($urandom_range(0, 7));
                bus.alu_ppp  = 3'($urandom);
                bus.alu_data = {$urandom, $urandom};
            end
            if (!(bus.ld_vld && !m_ld_taken)) begin
                set_ld($urandom_range(0, 9) < 4, 6'($urandom_range(0, 7)), 3'($urandom),
                       {$urandom, $urandom});
            end
            bus.chk_addr = 6'($urandom_range(0, 7));
            tick();
        end
        bus.alu_vld = 0;
        bus.ld_vld  = 0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Writeback-side driver for the 64x64 register file write port (wr_en, ppp, in_addr, in_data). It merges two result producers, the ALU (1 result/cycle, priority) and the load unit (valid/ready, buffered in a small FIFO), onto the single write port. It guarantees bounded load latency via a starvation counter, and exposes a pending-write check for the issue scoreboard. Sits between execute/memory stages and reg_file.

Parameters:
DATA_W, 64, register data width
ADDR_W, 6, register address width (64 entries)
PPP_W, 3, partial-precision/lane field width, passed through unmodified
FIFO_DEPTH, 4, load-result buffer entries (power of two, >=2)
STARVE_MAX, 8, consecutive ALU grants tolerated while FIFO non-empty

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_vld  in  1  ALU result valid
alu_addr  in  ADDR_W  ALU destination register
alu_ppp  in  PPP_W  ALU write lane field
alu_data  in  DATA_W  ALU result
alu_stall  out  1  registered; ALU result not consumed this cycle, upstream holds
ld_vld  in  1  load result valid
ld_rdy  out  1  FIFO can accept (count < FIFO_DEPTH)
ld_addr  in  ADDR_W  load destination register
ld_ppp  in  PPP_W  load write lane field
ld_data  in  DATA_W  load data
wr_en  out  1  registered write enable to reg_file
ppp  out  PPP_W  registered lane field to reg_file
in_addr  out  ADDR_W  registered write address to reg_file
in_data  out  DATA_W  registered write data to reg_file
chk_addr  in  ADDR_W  scoreboard query address
chk_hit  out  1  combinational; a write to chk_addr is pending
fifo_cnt  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1): wr_en=0, ppp=0, in_addr=0, in_data=0, alu_stall=0, FIFO empty, fifo_cnt=0, starve counter=0; ld_rdy forced 0 while rst=1, ld_rdy=1 the first cycle after release. Reset mid-operation discards all buffered loads.
- Grant per cycle (evaluated on current state):
  - ALU_WIN: alu_vld=1 and alu_stall=0 -> ALU fields registered to write port.
  - FIFO_WIN: FIFO non-empty and (alu_vld=0 or alu_stall=1) -> head popped and registered.
  - IDLE: otherwise, wr_en=0 next cycle; ppp/in_addr/in_data hold last values.
- Latency: ALU result sampled at edge N drives wr_en from N to N+1 (reg_file commits at N+1). Loads have no bypass; push at edge N, earliest write-port drive after edge N+1.
- FIFO: push when ld_vld&ld_rdy; pop on FIFO_WIN. Simultaneous push and pop allowed at any non-full occupancy (count unchanged). ld_rdy=0 when full, even if a pop occurs that cycle (no full bypass). Pointers wrap modulo FIFO_DEPTH. Loads are written in arrival order.
- Starvation: counter increments on each ALU_WIN with FIFO non-empty. It clears on FIFO_WIN or when the FIFO is empty. When it reaches STARVE_MAX, alu_stall=1 for exactly the next cycle (a forced FIFO_WIN) and the counter clears. While alu_stall=1, upstream holds alu_* stable; the held result is consumed the following cycle.
- chk_hit=1 if chk_addr equals the address of any valid FIFO entry, or if wr_en=1 and in_addr==chk_addr.
- Precondition (issue logic): no ALU write to a register with a pending load (checked via chk_hit). The block does not reorder for WAW.
- ppp is never interpreted; it is carried with its data.

Decomposition:
- Shared package rf_pkg: DATA_W/ADDR_W/PPP_W constants, PPP_FULL=3'b000 encoding, and the write-request struct {addr, ppp, data} used by reg_file and this block.
- One sub-module: wb_fifo (parameterised sync FIFO with push/pop, count, per-entry address/valid vectors for the chk_hit compare).

Test Plan:
- Reset: assert rst mid-stream with 3 loads buffered -> all outputs 0, fifo_cnt=0, ld_rdy=0 during reset and 1 one cycle after release.
- ALU only: alu_vld with addr=17, ppp=0, data=64'hDEAD_BEEF_0123_4567 -> wr_en=1, in_addr=17, in_data matches one cycle later. Back-to-back addr 22 and 13 (ppp=3'b010) -> consecutive writes, ppp passed through.
- Load only: ld_vld with addr=12, ppp=3'b100 into empty FIFO -> fifo_cnt=1, write port drives addr 12 two edges after push.
- Full FIFO: 5 loads with ALU busy -> ld_rdy=0 after the 4th, 5th held; after a pop, 5th accepted. Order of writes is 12, 13, 14, 15, 9.
- Starvation: continuous alu_vld with 1 load buffered -> after 8 ALU grants, alu_stall=1 for 1 cycle, load written, then the held ALU result is written next cycle with no loss or duplication.
- chk_hit: loads to addr 9 and 15 buffered; chk_addr=15 -> 1, chk_addr=16 -> 0; after both are written and wr_en drops -> 0.
